// File: rtl/load_replay_ctrl.sv
// load_replay_ctrl: load-unit responder for the load issue queue. Each issued
// load is followed through s1/s2 and gets exactly one outcome: a fast replay,
// a slow replay (after a refill/store-data wake) or success. Slow-replay loads
// park in a small wait buffer.
// Optional: define LOAD_REPLAY_TIMEOUT_EN to add an 8-bit per-entry watchdog
// that forces a waiting entry to READY after 255 cycles (lost wake recovery).
module load_replay_ctrl #(
    parameter int IDX_W    = 4,
    parameter int ROB_W    = 6,
    parameter int MSHR_W   = 2,
    parameter int SQ_W     = 5,
    parameter int RB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [IDX_W-1:0]  issue_idx,
    input  logic [ROB_W:0]    issue_rob,
    input  logic              s1_fast_fail,
    input  logic              s2_hit,
    input  logic              s2_miss,
    input  logic [MSHR_W-1:0] s2_mshr,
    input  logic              s2_fwd_wait,
    input  logic [SQ_W-1:0]   s2_sq_idx,
    input  logic              refill_en,
    input  logic [MSHR_W-1:0] refill_mshr,
    input  logic              sdata_en,
    input  logic [SQ_W-1:0]   sdata_sq_idx,
    input  logic              redirect,
    input  logic [ROB_W:0]    redirect_rob,
    output logic              reply_fast_en,
    output logic [IDX_W-1:0]  reply_fast_idx,
    output logic              reply_slow_en,
    output logic [IDX_W-1:0]  reply_slow_idx,
    output logic              success,
    output logic [IDX_W-1:0]  success_idx,
    output logic              rb_full
);
    localparam int RBI_W = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;

    typedef enum logic [1:0] {RB_FREE, RB_WAIT_REFILL, RB_WAIT_STORE, RB_READY} rb_state_e;

    function automatic logic is_young(input logic [ROB_W:0] rob, input logic [ROB_W:0] rr);
        return (rob[ROB_W] ^ rr[ROB_W]) ^ (rob[ROB_W-1:0] > rr[ROB_W-1:0]);
    endfunction

    logic              s1_v, s2_v, fp_v;
    logic [IDX_W-1:0]  s1_idx, s2_idx, fp_idx;
    logic [ROB_W:0]    s1_rob, s2_rob, fp_rob;

    rb_state_e         rb_st  [RB_DEPTH];
    rb_state_e         st_nx  [RB_DEPTH];
    logic [IDX_W-1:0]  rb_idx [RB_DEPTH];
    logic [ROB_W:0]    rb_rob [RB_DEPTH];
    logic [MSHR_W-1:0] rb_mshr[RB_DEPTH];
    logic [SQ_W-1:0]   rb_sq  [RB_DEPTH];
`ifdef LOAD_REPLAY_TIMEOUT_EN
    logic [7:0]        rb_cnt [RB_DEPTH];
`endif

    logic              s0_live, s1_live, s2_live, fp_live;
    logic              s1_fail, s2_hit_ok, s2_alloc, s2_fast;
    logic              alloc_found, slow_v;
    logic [RBI_W-1:0]  alloc_ptr, slow_sel;
    logic [IDX_W-1:0]  slow_idx_nx;
    rb_state_e         alloc_st;

    // Liveness after redirect kill and s2 outcome classification
    always_comb begin
        s0_live   = issue_en & ~(redirect & is_young(issue_rob, redirect_rob));
        s1_live   = s1_v & ~(redirect & is_young(s1_rob, redirect_rob));
        s2_live   = s2_v & ~(redirect & is_young(s2_rob, redirect_rob));
        fp_live   = fp_v & ~(redirect & is_young(fp_rob, redirect_rob));
        s1_fail   = s1_live & s1_fast_fail;
        s2_hit_ok = s2_live & s2_hit;
        // A load with no flag, or one that finds the buffer full, replays fast.
        s2_alloc  = s2_live & ~s2_hit & (s2_fwd_wait | s2_miss) & ~rb_full;
        s2_fast   = s2_live & ~s2_hit & (~(s2_fwd_wait | s2_miss) | rb_full);
        if (s2_fwd_wait)
            alloc_st = (sdata_en && sdata_sq_idx == s2_sq_idx) ? RB_READY : RB_WAIT_STORE;
        else
            alloc_st = (refill_en && refill_mshr == s2_mshr) ? RB_READY : RB_WAIT_REFILL;
    end

    // Free-entry search and full flag from the state registers
    always_comb begin
        rb_full     = 1'b1;
        alloc_found = 1'b0;
        alloc_ptr   = '0;
        for (int i = 0; i < RB_DEPTH; i++) begin
            if (rb_st[i] == RB_FREE) begin
                rb_full = 1'b0;
                if (!alloc_found) begin
                    alloc_found = 1'b1;
                    alloc_ptr   = RBI_W'(i);
                end
            end
        end
    end

    // Buffer next state (wake, timeout, kill, allocate), then pick the slow replay
    // from that next state so a wake reaches the output one cycle later.
    always_comb begin
        for (int i = 0; i < RB_DEPTH; i++) begin
            st_nx[i] = rb_st[i];
            if (rb_st[i] == RB_WAIT_REFILL && refill_en && rb_mshr[i] == refill_mshr)
                st_nx[i] = RB_READY;
            if (rb_st[i] == RB_WAIT_STORE && sdata_en && rb_sq[i] == sdata_sq_idx)
                st_nx[i] = RB_READY;
`ifdef LOAD_REPLAY_TIMEOUT_EN
            if ((rb_st[i] == RB_WAIT_REFILL || rb_st[i] == RB_WAIT_STORE) && rb_cnt[i] == 8'hFF)
                st_nx[i] = RB_READY;
`endif
            if (redirect && rb_st[i] != RB_FREE && is_young(rb_rob[i], redirect_rob))
                st_nx[i] = RB_FREE;
            if (s2_alloc && alloc_ptr == RBI_W'(i))
                st_nx[i] = alloc_st;
        end
        slow_v   = 1'b0;
        slow_sel = '0;
        for (int i = 0; i < RB_DEPTH; i++) begin
            if (!slow_v && st_nx[i] == RB_READY) begin
                slow_v   = 1'b1;
                slow_sel = RBI_W'(i);
            end
        end
        slow_idx_nx = (s2_alloc && alloc_ptr == slow_sel) ? s2_idx : rb_idx[slow_sel];
    end

    // Pipeline stages, fast-pending slot and registered replies
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0; s1_idx <= '0; s1_rob <= '0;
            s2_v <= 1'b0; s2_idx <= '0; s2_rob <= '0;
            fp_v <= 1'b0; fp_idx <= '0; fp_rob <= '0;
            reply_fast_en <= 1'b0; reply_fast_idx <= '0;
            reply_slow_en <= 1'b0; reply_slow_idx <= '0;
            success <= 1'b0; success_idx <= '0;
        end else begin
            s1_v   <= s0_live;
            s1_idx <= issue_idx;
            s1_rob <= issue_rob;
            s2_v   <= s1_live & ~s1_fast_fail;
            s2_idx <= s1_idx;
            s2_rob <= s1_rob;

            success     <= s2_hit_ok;
            success_idx <= s2_idx;

            reply_slow_en  <= slow_v;
            reply_slow_idx <= slow_idx_nx;

            // s1 has priority, then the parked load, then the s2 fallback.
            reply_fast_en <= s1_fail | fp_live | s2_fast;
            if (s1_fail)
                reply_fast_idx <= s1_idx;
            else if (fp_live)
                reply_fast_idx <= fp_idx;
            else if (s2_fast)
                reply_fast_idx <= s2_idx;

            if (s2_fast && (s1_fail || fp_live)) begin
                fp_v   <= 1'b1;
                fp_idx <= s2_idx;
                fp_rob <= s2_rob;
            end else if (!fp_live || !s1_fail) begin
                fp_v <= 1'b0;
            end
        end
    end

    // Wait-buffer entries; the entry chosen for slow replay is freed here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RB_DEPTH; i++) begin
                rb_st[i]   <= RB_FREE;
                rb_idx[i]  <= '0;
                rb_rob[i]  <= '0;
                rb_mshr[i] <= '0;
                rb_sq[i]   <= '0;
`ifdef LOAD_REPLAY_TIMEOUT_EN
                rb_cnt[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < RB_DEPTH; i++) begin
                rb_st[i] <= (slow_v && slow_sel == RBI_W'(i)) ? RB_FREE : st_nx[i];
                if (s2_alloc && alloc_ptr == RBI_W'(i)) begin
                    rb_idx[i]  <= s2_idx;
                    rb_rob[i]  <= s2_rob;
                    rb_mshr[i] <= s2_mshr;
                    rb_sq[i]   <= s2_sq_idx;
                end
`ifdef LOAD_REPLAY_TIMEOUT_EN
                if (s2_alloc && alloc_ptr == RBI_W'(i))
                    rb_cnt[i] <= '0;
                else if (rb_st[i] == RB_WAIT_REFILL || rb_st[i] == RB_WAIT_STORE)
                    rb_cnt[i] <= rb_cnt[i] + 8'd1;
`endif
            end
        end
    end
endmodule

// File: doc/load_replay_ctrl.md
Name: load_replay_ctrl

Overview:
- Per-pipeline responder on the load-unit side of the load issue queue protocol.
- Tracks each issued load entry through stages s1/s2 and returns exactly one outcome per issue, identified by its issue-queue bank index:
  - fast reply: re-issue now;
  - slow reply: re-issue after an external wake event;
  - success: free the entry.
- Holds slow-replay loads in a small wait buffer until a cache refill or store data arrives.
- Flushes state on backend redirect.

Parameters:
- IDX_W, 4, width of issue-queue bank index.
- ROB_W, 6, ROB index width excluding the dir bit.
- MSHR_W, 2, miss-handler id width.
- SQ_W, 5, store-queue index width.
- RB_DEPTH, 4, slow-replay buffer entries.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- issue_en  input  1  load issued into s0 this cycle.
- issue_idx  input  IDX_W  bank index of the issued load.
- issue_rob  input  ROB_W+1  {dir,idx} of the issued load.
- s1_fast_fail  input  1  s1 needs immediate replay (TLB miss or bank conflict).
- s2_hit  input  1  s2 data valid.
- s2_miss  input  1  s2 dcache miss.
- s2_mshr  input  MSHR_W  MSHR allocated for the miss.
- s2_fwd_wait  input  1  s2 store forward blocked on data.
- s2_sq_idx  input  SQ_W  blocking store index.
- refill_en  input  1  refill complete.
- refill_mshr  input  MSHR_W  refill id.
- sdata_en  input  1  store data written.
- sdata_sq_idx  input  SQ_W  store index written.
- redirect  input  1  backend redirect.
- redirect_rob  input  ROB_W+1  redirect robIdx.
- reply_fast_en  output  1  fast replay.
- reply_fast_idx  output  IDX_W  index for fast replay.
- reply_slow_en  output  1  slow replay.
- reply_slow_idx  output  IDX_W  index for slow replay.
- success  output  1  load completed.
- success_idx  output  IDX_W  index of completed load.
- rb_full  output  1  all buffer entries valid.

Behaviour:
- Reset: all pipeline valids, buffer entries and registered outputs are 0.
- Pipeline: s0→s1→s2 advance one stage per cycle; no stall. Each stage holds {valid, idx, rob}.
- Young-kill predicate: an item is younger than the redirect when (rob.dir ^ redirect_rob.dir) ^ (rob.idx > redirect_rob.idx) is 1.
  - Used for the pipeline stages and for buffer entries.
- s1:
  - If valid and s1_fast_fail, the s2 valid is cleared.
  - Next cycle: reply_fast_en=1 and reply_fast_idx=the s1 idx, registered.
- s2 priority (valid only): s2_hit > s2_fwd_wait > s2_miss.
  - Hit: next cycle success=1, success_idx=idx.
  - Otherwise: allocate the lowest free buffer entry in state WAIT_STORE (records sq_idx) or WAIT_REFILL (records mshr).
  - No flag set: treated as fast replay.
- Buffer full on allocation: the load falls back to a fast replay next cycle.
  - If s1 also issues a fast reply that cycle, s1 wins and the s2 load goes to a 1-deep fast-pending register, emitted the following cycle.
  - While fast-pending is occupied, a further full-buffer fallback is also held. Verification guarantees at most one per 2 cycles.
- Entry states: FREE → WAIT_REFILL/WAIT_STORE → READY → FREE.
  - WAIT_REFILL → READY when refill_en and mshr match.
  - WAIT_STORE → READY when sdata_en and sq_idx match.
  - A wake event in the same cycle as allocation with a matching id allocates directly in READY.
- Slow replay:
  - Each cycle, the lowest-index READY entry is emitted as reply_slow_en/idx (registered, 1-cycle latency).
  - That entry becomes FREE.
  - Maximum 1 per cycle.
- Redirect, same cycle:
  - Pipeline stages and buffer entries younger than redirect_rob are invalidated.
  - Outputs registered in that cycle for killed loads are suppressed.
  - Older items continue.
- rb_full = all entries not FREE, combinational from the state registers.
- Invariant: each issued, non-flushed load produces exactly one of reply_fast, reply_slow or success.
- Reset asserted mid-operation clears everything asynchronously; no outputs while reset is low.

Optional Feature:
- LOAD_REPLAY_TIMEOUT_EN defined: each WAIT entry has an 8-bit counter cleared at allocation. At 255 the entry is forced to READY, as protection against a lost wake event.
- Undefined: no counters; entries wait indefinitely.

Test Plan:
- Hit path: issue idx=3 at cycle 0, s2_hit at cycle 2 → success=1, success_idx=3 at cycle 3; no other reply.
- Fast fail: issue idx=5, s1_fast_fail at cycle 1 → reply_fast_en=1, idx=5 at cycle 2; the s2 flags at cycle 2 are ignored.
- Miss/refill: idx=7 misses with mshr=2; refill_mshr=1 then refill_mshr=2 → reply_slow idx=7 exactly 1 cycle after the mshr=2 refill.
- Full buffer: fill 4 entries in WAIT_REFILL, then a 5th miss idx=9 → rb_full=1, reply_fast idx=9 next cycle.
- Redirect: entries rob 10 and 14 waiting, redirect_rob=12 (same dir) → 14 freed, 10 retained; a later refill replays only 10.
- Same-cycle wake: s2_fwd_wait sq=4 with sdata_en sq=4 → entry allocated READY, reply_slow next cycle.
